muldiv_unit: RTL

//  Multicycle iterative multiply/divide unit for the multicycle datapath.
//  It consumes the MUL/SMUL/UMUL/DIV ALUControl codes (0100-0111) that the decoder emits when Instr[7:4]==1001.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multicycle iterative multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle, WIDTH steps per operation, followed by a sign-fix cycle and a
// one-cycle Done pulse. Results and flags hold until the next op's FIX.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi,
   output logic [1:0]       MulFlags
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_SMUL = 2'b01,
      OP_UMUL = 2'b10,
      OP_DIV  = 2'b11
   } op_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   a_q, a_d;          // multiplicand magnitude
   logic [WIDTH-1:0]   b_q, b_d;          // divisor (div) / unused copy (mul)
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d; // partial product high / remainder
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d; // multiplier->product low / dividend->quotient
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic [1:0]         flags_q, flags_d;

   logic               accept;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               is_smul_in;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] prod, prod_fixed;

   assign accept     = (state_q == S_IDLE) && Start && (ALUControl[3:2] == 2'b01);
   assign is_smul_in = (ALUControl[1:0] == OP_SMUL);
   assign a_mag      = (is_smul_in && SrcA[WIDTH-1]) ? -SrcA : SrcA;
   assign b_mag      = (is_smul_in && SrcB[WIDTH-1]) ? -SrcB : SrcB;

   // Multiply step: conditionally add multiplicand into the high half, then
   // shift the whole {carry,hi,lo} right by one.
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);

   // Restoring divide step: shift the next dividend bit into the remainder and
   // try to subtract the divisor.
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_ok    = (div_shift >= {1'b0, b_q});
   assign div_diff  = div_shift[WIDTH-1:0] - b_q;

   assign prod       = {acc_hi_q, acc_lo_q};
   assign prod_fixed = ((op_q == OP_SMUL) && sign_q) ? -prod : prod;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_CALC;
         S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      unique case (state_q)
         S_CALC, S_FIX: Busy = 1'b1;
         S_DONE:        Done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: operand latch, iteration, result load
   always_comb begin
      op_d     = op_q;
      sign_d   = sign_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      cnt_d    = cnt_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      flags_d  = flags_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d     = op_e'(ALUControl[1:0]);
               sign_d   = is_smul_in && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
               a_d      = a_mag;
               b_d      = b_mag;
               acc_hi_d = '0;
               acc_lo_d = (ALUControl[1:0] == OP_DIV) ? SrcA : b_mag;
               cnt_d    = CNT_W'(WIDTH);
            end
         end
         S_CALC: begin
            if (op_q == OP_DIV) begin
               acc_hi_d = div_ok ? div_diff : div_shift[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
            end else begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
         end
         S_FIX: begin
            unique case (op_q)
               OP_MUL: begin
                  res_hi_d = '0;
                  res_lo_d = acc_lo_q;
                  flags_d  = {acc_lo_q[WIDTH-1], (acc_lo_q == '0)};
               end
               OP_DIV: begin
                  res_hi_d = acc_hi_q;
                  res_lo_d = acc_lo_q;
                  flags_d  = {acc_lo_q[WIDTH-1], (acc_lo_q == '0)};
               end
               default: begin
                  res_hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                  res_lo_d = prod_fixed[WIDTH-1:0];
                  flags_d  = {prod_fixed[2*WIDTH-1], (prod_fixed == '0)};
               end
            endcase
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= OP_MUL;
         sign_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         flags_q  <= '0;
      end else begin
         op_q     <= op_d;
         sign_q   <= sign_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         flags_q  <= flags_d;
      end
   end

   assign ResultLo = res_lo_q;
   assign ResultHi = res_hi_q;
   assign MulFlags = flags_q;

endmodule
